// File: rtl/cache_axi_bridge_pkg.sv
// rtl/cache_axi_bridge_pkg.sv - shared types, constants and address helpers for the cache AXI bridge
package cache_axi_bridge_pkg;
  localparam int         LINE_WORDS     = 4;
  localparam logic [2:0] RD_TYPE_LINE   = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_B}  wr_state_e;

  // Line transfers start on the line boundary; single transfers keep the byte address.
  function automatic logic [31:0] xfer_addr(input logic [2:0] t, input logic [31:0] a);
    return (t == RD_TYPE_LINE) ? {a[31:4], 4'b0} : a;
  endfunction

  function automatic logic [2:0] xfer_size(input logic [2:0] t);
    return (t == RD_TYPE_LINE) ? 3'd2 : {1'b0, t[1:0]};
  endfunction
endpackage

// File: rtl/cache_axi_bridge_if.sv
// rtl/cache_axi_bridge_if.sv - 32-bit AXI master bundle used by the cache bridge
interface cache_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wid, wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wid, wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );
endinterface

// File: rtl/cache_axi_bridge_wr_channel.sv
// rtl/cache_axi_bridge_wr_channel.sv - write FSM: latches one cache write and drives AW/W/B
module cache_axi_bridge_wr_channel #(
  parameter int LINE_WORDS = cache_axi_bridge_pkg::LINE_WORDS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         busy,
  output logic [27:0]  line_addr,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic         bvalid,
  output logic         bready
);
  import cache_axi_bridge_pkg::*;

  wr_state_e    state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [2:0]   type_q, type_d;
  logic [3:0]   strb_q, strb_d;
  logic [127:0] data_q, data_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         aw_done_q, aw_done_d;
  logic         w_done_q, w_done_d;
  logic         is_line;

  assign is_line   = (type_q == RD_TYPE_LINE);
  assign awaddr    = xfer_addr(type_q, addr_q);
  assign awlen     = is_line ? 8'(LINE_WORDS - 1) : 8'd0;
  assign awsize    = xfer_size(type_q);
  assign awburst   = AXI_BURST_INCR;
  assign awvalid   = (state_q == W_SEND) && !aw_done_q;
  assign wvalid    = (state_q == W_SEND) && !w_done_q;
  assign wdata     = data_q[{cnt_q, 5'd0} +: 32];
  assign wstrb     = is_line ? 4'hf : strb_q;
  assign wlast     = (cnt_q == awlen[1:0]);
  assign bready    = (state_q == W_B);
  assign wr_rdy    = (state_q == W_IDLE);
  assign busy      = (state_q != W_IDLE);
  assign line_addr = addr_q[31:4];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    type_d    = type_q;
    strb_d    = strb_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      W_IDLE: if (wr_req) begin
        addr_d    = wr_addr;
        type_d    = wr_type;
        strb_d    = wr_wstrb;
        data_d    = wr_data;
        cnt_d     = 2'd0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = W_SEND;
      end
      W_SEND: begin
        // AW and W complete independently; the flags include this cycle's handshakes.
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready) begin
          cnt_d = cnt_q + 2'd1;
          if (wlast) w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) state_d = W_B;
      end
      W_B: if (bvalid) begin
        cnt_d     = 2'd0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= W_IDLE;
      addr_q    <= '0;
      type_q    <= '0;
      strb_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      type_q    <= type_d;
      strb_q    <= strb_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: rtl/cache_axi_bridge.sv
// rtl/cache_axi_bridge.sv - cache miss/refill and writeback requests onto one 32-bit AXI master
module cache_axi_bridge #(
  parameter int         LINE_WORDS = cache_axi_bridge_pkg::LINE_WORDS,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_req,
  input  logic [2:0]           rd_type,
  input  logic [31:0]          rd_addr,
  output logic                 rd_rdy,
  output logic                 ret_valid,
  output logic                 ret_last,
  output logic [31:0]          ret_data,
  input  logic                 wr_req,
  input  logic [2:0]           wr_type,
  input  logic [31:0]          wr_addr,
  input  logic [3:0]           wr_wstrb,
  input  logic [127:0]         wr_data,
  output logic                 wr_rdy,
  cache_axi_bridge_if.master   axi
);
  import cache_axi_bridge_pkg::*;

  rd_state_e   r_state_q, r_state_d;
  logic [31:0] raddr_q, raddr_d;
  logic [2:0]  rtype_q, rtype_d;
  logic        wr_busy;
  logic [27:0] wr_line;
  logic        hazard;
  logic        unused_resp;

  // A read may not overtake a write to the same line, whether pending or being accepted now.
  assign hazard = (wr_busy && (wr_line == rd_addr[31:4])) ||
                  (wr_req && wr_rdy && (wr_addr[31:4] == rd_addr[31:4]));
  assign rd_rdy = (r_state_q == R_IDLE) && !hazard;

  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rtype_d   = rtype_q;
    case (r_state_q)
      R_IDLE: if (rd_req && rd_rdy) begin
        raddr_d   = rd_addr;
        rtype_d   = rd_type;
        r_state_d = R_AR;
      end
      R_AR:    if (axi.arready) r_state_d = R_DATA;
      R_DATA:  if (axi.rvalid && axi.rlast) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rtype_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rtype_q   <= rtype_d;
    end
  end

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = xfer_addr(rtype_q, raddr_q);
  assign axi.arlen   = (rtype_q == RD_TYPE_LINE) ? 8'(LINE_WORDS - 1) : 8'd0;
  assign axi.arsize  = xfer_size(rtype_q);
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arvalid = (r_state_q == R_AR);
  assign axi.rready  = (r_state_q == R_DATA);
  assign ret_valid   = axi.rvalid && (r_state_q == R_DATA);
  assign ret_last    = axi.rlast && ret_valid;
  assign ret_data    = axi.rdata;
  assign axi.awid    = AXI_ID;
  assign axi.wid     = AXI_ID;
  assign unused_resp = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};

  cache_axi_bridge_wr_channel #(.LINE_WORDS(LINE_WORDS)) u_wr (
    .clk       (clk),
    .reset     (reset),
    .wr_req    (wr_req),
    .wr_type   (wr_type),
    .wr_addr   (wr_addr),
    .wr_wstrb  (wr_wstrb),
    .wr_data   (wr_data),
    .wr_rdy    (wr_rdy),
    .busy      (wr_busy),
    .line_addr (wr_line),
    .awaddr    (axi.awaddr),
    .awlen     (axi.awlen),
    .awsize    (axi.awsize),
    .awburst   (axi.awburst),
    .awvalid   (axi.awvalid),
    .awready   (axi.awready),
    .wdata     (axi.wdata),
    .wstrb     (axi.wstrb),
    .wlast     (axi.wlast),
    .wvalid    (axi.wvalid),
    .wready    (axi.wready),
    .bvalid    (axi.bvalid),
    .bready    (axi.bready)
  );
endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb/tb_cache_axi_bridge.sv - directed self-checking bench for cache_axi_bridge
module tb_cache_axi_bridge;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rd_req = 1'b0;
  logic [2:0]   rd_type = 3'd0;
  logic [31:0]  rd_addr = 32'd0;
  logic         rd_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req = 1'b0;
  logic [2:0]   wr_type = 3'd0;
  logic [31:0]  wr_addr = 32'd0;
  logic [3:0]   wr_wstrb = 4'd0;
  logic [127:0] wr_data = 128'd0;
  logic         wr_rdy;

  cache_axi_bridge_if axi();

  cache_axi_bridge #(.LINE_WORDS(4), .AXI_ID(4'd0)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .axi(axi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // slave model configuration (written only by the main process)
  logic [31:0] r_mem [4];
  bit          r_toggle = 0, w_toggle = 0;
  int          aw_delay = 0;

  // slave model state and observations (written only by the posedge process)
  int          cyc = 0, r_beat = 0, aw_wait = 0, b_cnt = 0;
  bit          r_pend = 0, aw_got = 0, w_got = 0, b_pend = 0;
  logic [7:0]  r_len = 8'd0;
  logic [31:0] ar_addr_s, aw_addr_s;
  logic [7:0]  ar_len_s, aw_len_s;
  logic [2:0]  ar_size_s, aw_size_s;
  logic [1:0]  ar_burst_s, aw_burst_s;
  int          rd_acc_cyc = 0, wr_acc_cyc = 0, aw_cyc = 0, wlast_cyc = 0, b_cyc = 0;
  logic [31:0] ret_q[$];
  logic        ret_last_q[$];
  int          ret_cyc_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  logic        wl_q[$];

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; aw_wait = 0;
    end else begin
      if (rd_req && rd_rdy) rd_acc_cyc = cyc;
      if (wr_req && wr_rdy) wr_acc_cyc = cyc;
      if (ret_valid) begin
        ret_q.push_back(ret_data); ret_last_q.push_back(ret_last); ret_cyc_q.push_back(cyc);
      end
      if (axi.rvalid && axi.rready) begin
        r_beat++;
        if (axi.rlast) r_pend = 0;
      end
      if (axi.arvalid && axi.arready) begin
        ar_addr_s = axi.araddr; ar_len_s = axi.arlen; ar_size_s = axi.arsize; ar_burst_s = axi.arburst;
        r_len = axi.arlen; r_beat = 0; r_pend = 1;
      end
      if (axi.awvalid) begin
        if (axi.awready) begin
          aw_addr_s = axi.awaddr; aw_len_s = axi.awlen; aw_size_s = axi.awsize; aw_burst_s = axi.awburst;
          aw_got = 1; aw_wait = 0; aw_cyc = cyc;
        end else aw_wait++;
      end
      if (axi.wvalid && axi.wready) begin
        wd_q.push_back(axi.wdata); ws_q.push_back(axi.wstrb); wl_q.push_back(axi.wlast);
        if (axi.wlast) begin w_got = 1; wlast_cyc = cyc; end
      end
      if (axi.bvalid && axi.bready) begin b_pend = 0; b_cnt++; b_cyc = cyc; end
      if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
    end
  end

  always @(negedge clk) begin
    axi.arready = 1'b1;
    axi.rid     = 4'd0;
    axi.rresp   = 2'd0;
    axi.rvalid  = r_pend && (!r_toggle || cyc[0]);
    axi.rdata   = r_mem[r_beat[1:0]];
    axi.rlast   = (r_beat == int'(r_len));
    axi.awready = (aw_wait >= aw_delay);
    axi.wready  = !w_toggle || cyc[0];
    axi.bid     = 4'd0;
    axi.bresp   = 2'd0;
    axi.bvalid  = b_pend;
  end

  task automatic issue_read(input logic [2:0] t, input logic [31:0] a);
    rd_req = 1'b1; rd_type = t; rd_addr = a; #1;
    for (int i = 0; i < 100 && !rd_rdy; i++) begin @(negedge clk); #1; end
    check("rd_accept", rd_rdy, 1);
    @(negedge clk); rd_req = 1'b0;
  endtask

  task automatic issue_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                             input logic [127:0] d);
    wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d; #1;
    for (int i = 0; i < 100 && !wr_rdy; i++) begin @(negedge clk); #1; end
    check("wr_accept", wr_rdy, 1);
    @(negedge clk); wr_req = 1'b0;
  endtask

  task automatic wait_ret(input int target);
    int i = 0;
    while (i < 100 && ret_q.size() < target) begin @(negedge clk); i++; end
    check("ret_wait", ret_q.size() >= target, 1);
  endtask

  task automatic wait_b(input int target);
    int i = 0;
    while (i < 100 && b_cnt < target) begin @(negedge clk); i++; end
    check("b_wait", b_cnt >= target, 1);
  endtask

  task automatic wait_idle();
    int i = 0;
    #1;
    while (i < 200 && !(rd_rdy && wr_rdy && !r_pend && !b_pend)) begin @(negedge clk); #1; i++; end
    check("idle_reached", i < 200, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb, wb, bb;
    bit early;
    logic [127:0] line_d;
    logic [31:0] exp_w [4];
    line_d = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    exp_w  = '{32'hAAAA_0000, 32'hBBBB_0001, 32'hCCCC_0002, 32'hDDDD_0003};
    r_mem  = '{32'h11, 32'h22, 32'h33, 32'h44};

    // reset state
    repeat (2) @(negedge clk); #1;
    check("rst_arvalid", axi.arvalid, 0); check("rst_awvalid", axi.awvalid, 0);
    check("rst_wvalid", axi.wvalid, 0);   check("rst_rready", axi.rready, 0);
    check("rst_bready", axi.bready, 0);   check("rst_ret_valid", ret_valid, 0);
    check("rst_ret_last", ret_last, 0);   check("rst_rd_rdy", rd_rdy, 1);
    check("rst_wr_rdy", wr_rdy, 1);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // line refill
    rb = ret_q.size();
    issue_read(3'b100, 32'h1C00_0014);
    wait_ret(rb + 4);
    check("ar_addr", ar_addr_s, 32'h1C00_0010); check("ar_len", ar_len_s, 3);
    check("ar_size", ar_size_s, 2);             check("ar_burst", ar_burst_s, 1);
    check("refill_cnt", ret_q.size() - rb, 4);
    for (int i = 0; i < 4 && rb + i < ret_q.size(); i++) begin
      check($sformatf("refill_data%0d", i), ret_q[rb+i], 32'(17 * (i + 1)));
      check($sformatf("refill_last%0d", i), ret_last_q[rb+i], i == 3);
    end
    if (ret_cyc_q.size() > rb) check("refill_latency", ret_cyc_q[rb] - rd_acc_cyc, 2);
    wait_idle();
    check("refill_rd_rdy", rd_rdy, 1);

    // single-byte write
    wb = wd_q.size(); bb = b_cnt;
    issue_write(3'b000, 32'h0000_0003, 4'b1000, {96'd0, 32'hAA00_0000});
    early = 0;
    for (int i = 0; i < 60 && b_cnt == bb; i++) begin #1; if (wr_rdy) early = 1; @(negedge clk); end
    check("byte_wr_rdy_early", early, 0);
    check("byte_b_cnt", b_cnt - bb, 1);
    #1 check("byte_wr_rdy_after_b", wr_rdy, 1);
    check("byte_aw_addr", aw_addr_s, 32'h3); check("byte_aw_len", aw_len_s, 0);
    check("byte_aw_size", aw_size_s, 0);     check("byte_beats", wd_q.size() - wb, 1);
    if (wd_q.size() > wb) begin
      check("byte_wdata", wd_q[wb], 32'hAA00_0000);
      check("byte_wstrb", ws_q[wb], 4'b1000);
      check("byte_wlast", wl_q[wb], 1);
    end

    // line writeback, AW held off so W finishes first
    @(negedge clk);
    aw_delay = 6; wb = wd_q.size(); bb = b_cnt;
    issue_write(3'b100, 32'h2000_0008, 4'b0001, line_d);
    wait_b(bb + 1);
    check("wb_aw_addr", aw_addr_s, 32'h2000_0000); check("wb_aw_len", aw_len_s, 3);
    check("wb_aw_size", aw_size_s, 2);             check("wb_aw_burst", aw_burst_s, 1);
    check("wb_beats", wd_q.size() - wb, 4);
    for (int i = 0; i < 4 && wb + i < wd_q.size(); i++) begin
      check($sformatf("wb_data%0d", i), wd_q[wb+i], exp_w[i]);
      check($sformatf("wb_strb%0d", i), ws_q[wb+i], 4'hf);
      check($sformatf("wb_last%0d", i), wl_q[wb+i], i == 3);
    end
    check("wb_w_before_aw", wlast_cyc < aw_cyc, 1);
    check("wb_aw_cycle", aw_cyc - wr_acc_cyc, 7);
    check("wb_b_after_aw", b_cyc > aw_cyc, 1);
    wait_idle();

    // hazard: pending writeback to line 0x100
    aw_delay = 10;
    issue_write(3'b100, 32'h0000_0100, 4'hf, line_d);
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h0000_0104; #1;
    check("hazard_same_line", rd_rdy, 0);
    rd_addr = 32'h0000_0200; #1;
    check("hazard_other_line", rd_rdy, 1);
    @(negedge clk); rd_req = 1'b0;
    check("other_line_accept_cyc", rd_acc_cyc - wr_acc_cyc, 1);
    rb = ret_q.size();
    wait_ret(rb + 4);
    issue_read(3'b100, 32'h0000_0104);
    check("hazard_b_cycle", b_cyc - wr_acc_cyc, 12);
    check("hazard_release_cyc", rd_acc_cyc - b_cyc, 1);
    wait_idle();
    aw_delay = 0;

    // simultaneous requests: same line then different lines
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h0000_0400;
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_0404; wr_data = line_d; #1;
    check("same_line_rd_rdy", rd_rdy, 0);
    check("same_line_wr_rdy", wr_rdy, 1);
    @(negedge clk); rd_req = 1'b0; wr_req = 1'b0;
    wait_idle();
    rd_req = 1'b1; rd_addr = 32'h0000_0200;
    wr_req = 1'b1; wr_addr = 32'h0000_0300; #1;
    check("diff_line_rd_rdy", rd_rdy, 1);
    check("diff_line_wr_rdy", wr_rdy, 1);
    @(negedge clk); rd_req = 1'b0; wr_req = 1'b0;
    check("diff_line_same_cycle", rd_acc_cyc - wr_acc_cyc, 0);
    wait_idle();

    // backpressure on R and W
    r_toggle = 1; w_toggle = 1;
    r_mem = '{32'h5050_0000, 32'h5050_0001, 32'h5050_0002, 32'h5050_0003};
    rb = ret_q.size();
    issue_read(3'b100, 32'h0000_0500);
    wait_ret(rb + 4);
    wait_idle();
    check("bp_ret_cnt", ret_q.size() - rb, 4);
    for (int i = 0; i < 4 && rb + i < ret_q.size(); i++)
      check($sformatf("bp_ret%0d", i), ret_q[rb+i], 32'h5050_0000 + 32'(i));
    wb = wd_q.size(); bb = b_cnt;
    issue_write(3'b100, 32'h0000_0600, 4'hf, line_d);
    wait_b(bb + 1);
    check("bp_w_beats", wd_q.size() - wb, 4);
    for (int i = 0; i < 4 && wb + i < wd_q.size(); i++)
      check($sformatf("bp_wdata%0d", i), wd_q[wb+i], exp_w[i]);
    wait_idle();
    r_toggle = 0; w_toggle = 0;

    // reset during beat 2 of a refill
    r_mem = '{32'h61, 32'h62, 32'h63, 32'h64};
    rb = ret_q.size();
    issue_read(3'b100, 32'h0000_0700);
    wait_ret(rb + 2);
    reset = 1'b1;
    @(negedge clk); #1;
    check("mid_rst_ret_valid", ret_valid, 0); check("mid_rst_arvalid", axi.arvalid, 0);
    check("mid_rst_rready", axi.rready, 0);   check("mid_rst_rd_rdy", rd_rdy, 1);
    reset = 1'b0;
    @(negedge clk);
    rb = ret_q.size();
    issue_read(3'b100, 32'h0000_0800);
    wait_ret(rb + 4);
    check("post_rst_cnt", ret_q.size() - rb, 4);
    for (int i = 0; i < 4 && rb + i < ret_q.size(); i++)
      check($sformatf("post_rst_data%0d", i), ret_q[rb+i], 32'h61 + 32'(i));
    if (ret_last_q.size() >= rb + 4) check("post_rst_last", ret_last_q[rb+3], 1);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
